// File: rtl/chash_pkg.sv
// Shared definitions for the challenge-polynomial placement sequencer:
// FSM states, c-region geometry, candidate field positions and lane widths.
package chash_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_ISSUE,
    S_WAIT1,
    S_WAIT2,
    S_COMMIT,
    S_DONE
  } state_t;

  localparam int unsigned C_WORDS  = 256;
  localparam int unsigned WC_W     = 8;
  localparam int unsigned PC_W     = 6;
  localparam int unsigned ADDR_W   = 11;

  // Candidate layout: [9:1] coefficient index, [0] sign.
  localparam int unsigned CAND_W   = 10;
  localparam int unsigned IDX_MSB  = 9;
  localparam int unsigned IDX_LSB  = 1;

  localparam int unsigned LANE24_W = 48;
  localparam int unsigned LANE25_W = 50;

  // Word holding a coefficient: two coefficients per word, so drop the
  // low index bit (the half selector).
  function automatic logic [WC_W-1:0] word_of(input logic [CAND_W-1:0] cand);
    return cand[IDX_MSB:IDX_LSB+1];
  endfunction

  // c-region word address; {base, word} zero-extended to the RAM address width.
  function automatic logic [ADDR_W-1:0] c_addr(input logic [1:0] base,
                                               input logic [WC_W-1:0] word);
    return {1'b0, base, word};
  endfunction

endpackage

// File: rtl/chash_sample_ctrl.sv
// Sequencer for the challenge-polynomial placement datapath: clears the c
// region, then streams hash candidates through read -> datapath -> write-back
// until W nonzero coefficients are placed.
// Optional: define CHASH_REJECT_CNT_EN to add the rej_cnt output.
module chash_sample_ctrl
  import chash_pkg::*;
#(
  parameter int unsigned W    = 19,
  parameter logic [1:0]  BASE = 2'b11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [15:0]         hin_data,
  input  logic                hin_valid,
  output logic                hin_ready,
  output logic [ADDR_W-1:0]   mem_raddr,
  output logic [15:0]         dp_chash_addr,
  output logic                dp_in_flag,
  input  logic [ADDR_W-1:0]   dp_addr,
  input  logic [LANE24_W-1:0] dp_dout24,
  input  logic [LANE25_W-1:0] dp_dout25,
  input  logic                dp_flag,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [LANE24_W-1:0] mem_wdata24,
  output logic [LANE25_W-1:0] mem_wdata25,
  output logic                busy,
  output logic                done
`ifdef CHASH_REJECT_CNT_EN
  ,
  output logic [15:0]         rej_cnt
`endif
);

  localparam logic [PC_W-1:0] PC_LAST = PC_W'(W - 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(C_WORDS - 1);

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wc_q, wc_d;
  logic [CAND_W-1:0] cand_q, cand_d;
  logic [PC_W-1:0]   pc_q, pc_d;

  // hin_data[15:10] carry no information for placement.
  logic unused_hin_hi;
  assign unused_hin_hi = ^hin_data[15:CAND_W];

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    cand_d  = cand_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          wc_d    = '0;
          pc_d    = '0;
        end
      end
      S_CLEAR: begin
        wc_d = wc_q + WC_W'(1);
        if (wc_q == WC_LAST) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (hin_valid) begin
          cand_d  = hin_data[CAND_W-1:0];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT1;
      S_WAIT1: state_d = S_WAIT2;
      S_WAIT2: state_d = S_COMMIT;
      S_COMMIT: begin
        if (dp_flag) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = (pc_q == PC_LAST) ? S_DONE : S_FETCH;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and counter registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wc_q    <= '0;
      cand_q  <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      cand_q  <= cand_d;
      pc_q    <= pc_d;
    end
  end

  // Output decode from the registered state; COMMIT forwards the datapath
  // word combinationally so the write lands in the same cycle.
  always_comb begin
    hin_ready     = 1'b0;
    mem_raddr     = '0;
    dp_chash_addr = '0;
    dp_in_flag    = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = '0;
    mem_wdata24   = '0;
    mem_wdata25   = '0;
    unique case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = c_addr(BASE, wc_q);
      end
      S_FETCH: hin_ready = hin_valid;
      S_ISSUE: begin
        dp_in_flag    = 1'b1;
        mem_raddr     = c_addr(BASE, word_of(cand_q));
        dp_chash_addr = {6'b0, cand_q};
      end
      S_WAIT1, S_WAIT2: dp_chash_addr = {6'b0, cand_q};
      S_COMMIT: begin
        dp_chash_addr = {6'b0, cand_q};
        if (dp_flag) begin
          mem_we      = 1'b1;
          mem_waddr   = dp_addr;
          mem_wdata24 = dp_dout24;
          mem_wdata25 = dp_dout25;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

`ifdef CHASH_REJECT_CNT_EN
  logic [15:0] rej_cnt_q, rej_cnt_d;

  // Rejected-commit counter: cleared on an accepted start, saturating.
  always_comb begin
    rej_cnt_d = rej_cnt_q;
    if (state_q == S_IDLE && start) begin
      rej_cnt_d = '0;
    end else if (state_q == S_COMMIT && !dp_flag && rej_cnt_q != '1) begin
      rej_cnt_d = rej_cnt_q + 16'd1;
    end
  end

  // Rejected-commit counter register.
  always_ff @(posedge clk) begin
    if (!rst) rej_cnt_q <= '0;
    else      rej_cnt_q <= rej_cnt_d;
  end

  assign rej_cnt = rej_cnt_q;
`endif

endmodule

// File: tb/tb_chash_sample_ctrl.sv
// Bench for chash_sample_ctrl with a RAM model and a behavioural placement
// datapath. Coefficient layout in the datapath model: word = index>>1,
// half = index[0] (half 1 in the upper lane bits); +1 -> 1, -1 -> 24'hfc0000
// / 25'h1fc0000; an all-zero slot is empty.
`timescale 1ns/1ps
module tb_chash_sample_ctrl;

  localparam int TB_W = 3;
  localparam int RBASE = 768;  // 11'h300

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] hin_data = '0;
  logic        hin_valid = 1'b0;
  logic        hin_ready;
  logic [10:0] mem_raddr;
  logic [15:0] dp_chash_addr;
  logic        dp_in_flag;
  logic [10:0] dp_addr;
  logic [47:0] dp_dout24;
  logic [49:0] dp_dout25;
  logic        dp_flag;
  logic        mem_we;
  logic [10:0] mem_waddr;
  logic [47:0] mem_wdata24;
  logic [49:0] mem_wdata25;
  logic        busy;
  logic        done;
`ifdef CHASH_REJECT_CNT_EN
  logic [15:0] rej_cnt;
`endif

  chash_sample_ctrl #(.W(TB_W), .BASE(2'b11)) dut (
    .clk(clk), .rst(rst), .start(start),
    .hin_data(hin_data), .hin_valid(hin_valid), .hin_ready(hin_ready),
    .mem_raddr(mem_raddr), .dp_chash_addr(dp_chash_addr), .dp_in_flag(dp_in_flag),
    .dp_addr(dp_addr), .dp_dout24(dp_dout24), .dp_dout25(dp_dout25), .dp_flag(dp_flag),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata24(mem_wdata24),
    .mem_wdata25(mem_wdata25), .busy(busy), .done(done)
`ifdef CHASH_REJECT_CNT_EN
    , .rej_cnt(rej_cnt)
`endif
  );

  always #5 clk = ~clk;

  // RAM model (read latency 1) and datapath model
  logic [47:0] ram24 [0:2047];
  logic [49:0] ram25 [0:2047];
  logic        fill_req = 1'b0;
  logic        stray = 1'b0;
  logic [47:0] rd24, w2_24, w3_24;
  logic [49:0] rd25, w2_25, w3_25;
  logic        p1 = 1'b0, p2 = 1'b0, p3 = 1'b0;
  logic [9:0]  c3 = '0;

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 256; i++) begin
        ram24[RBASE+i] <= 48'({$urandom(), $urandom()}) | 48'd1;
        ram25[RBASE+i] <= 50'({$urandom(), $urandom()}) | 50'd1;
      end
    end else if (mem_we) begin
      ram24[mem_waddr] <= mem_wdata24;
      ram25[mem_waddr] <= mem_wdata25;
    end
    rd24 <= ram24[mem_raddr];
    rd25 <= ram25[mem_raddr];
    p1 <= dp_in_flag; p2 <= p1; p3 <= p2;
    w2_24 <= rd24; w2_25 <= rd25;
    w3_24 <= w2_24; w3_25 <= w2_25;
    c3 <= dp_chash_addr[9:0];
  end

  logic [23:0] v24;
  logic [24:0] v25;
  logic        slot_empty;
  logic [47:0] n24;
  logic [49:0] n25;
  always_comb begin
    v24 = c3[0] ? 24'd1 : 24'hfc0000;
    v25 = c3[0] ? 25'd1 : 25'h1fc0000;
    n24 = w3_24;
    n25 = w3_25;
    if (c3[1]) begin
      slot_empty = (w3_24[47:24] == 24'd0) && (w3_25[49:25] == 25'd0);
      n24[47:24] = v24;
      n25[49:25] = v25;
    end else begin
      slot_empty = (w3_24[23:0] == 24'd0) && (w3_25[24:0] == 25'd0);
      n24[23:0] = v24;
      n25[24:0] = v25;
    end
    dp_flag   = (p3 && slot_empty) || stray;
    dp_addr   = p3 ? {3'b011, c3[9:2]} : 11'h7ff;
    dp_dout24 = p3 ? n24 : '1;
    dp_dout25 = p3 ? n25 : '1;
  end

  // Scoreboard state
  int n_asserts = 0;
  int n_fail = 0;
  logic [15:0] stim_q[$];
  logic        exp_acc[$];
  int          exp_n, exp_rej, exp_pc;
  int          exp_coef[0:511];

  logic [15:0] obs_cand[$];
  logic [10:0] obs_raddr[$];
  logic        obs_cwe[$];
  logic [10:0] obs_cwaddr[$];
  int          obs_issue_k[$];
  int          obs_clear_len, obs_done_k, obs_done_cnt, obs_unstable;
  int          obs_stall_bad, obs_consumed, obs_start_k;
  bit          obs_timeout, obs_start_hit;
  logic        obs_after_start_we;
  logic [3:0]  obs_post;

  function automatic logic [23:0] enc24(input int v);
    if (v > 0) return 24'd1;
    if (v < 0) return 24'hfc0000;
    return 24'd0;
  endfunction

  function automatic logic [24:0] enc25(input int v);
    if (v > 0) return 25'd1;
    if (v < 0) return 25'h1fc0000;
    return 25'd0;
  endfunction

  // Reference: fresh zero region, place candidates until TB_W accepted.
  task automatic model_run();
    int idx;
    exp_acc.delete();
    exp_n = 0; exp_rej = 0; exp_pc = 0;
    for (int i = 0; i < 512; i++) exp_coef[i] = 0;
    for (int i = 0; i < stim_q.size() && exp_pc < TB_W; i++) begin
      idx = int'(stim_q[i][9:1]);
      exp_n++;
      if (exp_coef[idx] == 0) begin
        exp_coef[idx] = stim_q[i][0] ? 1 : -1;
        exp_acc.push_back(1'b1);
        exp_pc++;
      end else begin
        exp_acc.push_back(1'b0);
        exp_rej++;
      end
    end
  endtask

  // Drive one full start..done run from stim_q, recording observations,
  // then compare against the model.
  task automatic run_stream(input string name, input int stall_cycles,
                            input bit start_in_commit, input int gap_max);
    int k, qi, gap, stall, last_issue;
    obs_cand.delete(); obs_raddr.delete(); obs_cwe.delete();
    obs_cwaddr.delete(); obs_issue_k.delete();
    obs_clear_len = 0; obs_done_k = -1; obs_done_cnt = 0; obs_unstable = 0;
    obs_stall_bad = 0; obs_consumed = 0; obs_start_k = -10; obs_timeout = 0;
    obs_start_hit = 0; obs_after_start_we = 1'b0;
    model_run();

    @(posedge clk); #1; fill_req = 1'b1;
    @(posedge clk); #1; fill_req = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; #1;
    while (mem_we === 1'b1 && obs_clear_len < 400) begin
      obs_clear_len++;
      @(posedge clk); #2;
    end

    k = 0; qi = 0; gap = 0; stall = stall_cycles; last_issue = -100;
    while (obs_done_cnt == 0 && k < 3000) begin
      @(posedge clk); #1; k++;
      start = 1'b0;
      stray = 1'b0;
      if (stall > 0) begin
        hin_valid = 1'b0; stray = 1'b1;
      end else if (gap > 0) begin
        hin_valid = 1'b0; gap--;
      end else begin
        hin_valid = (qi < stim_q.size());
      end
      hin_data = (qi < stim_q.size()) ? stim_q[qi] : 16'h0;
      if (start_in_commit && !obs_start_hit && k == last_issue + 3) begin
        start = 1'b1; obs_start_hit = 1; obs_start_k = k;
      end
      #1;
      if (stall > 0) begin
        if (dp_in_flag || hin_ready || !busy || mem_we) obs_stall_bad++;
        stall--;
      end
      if (k == obs_start_k + 1) obs_after_start_we = mem_we;
      if (hin_valid && hin_ready) begin
        qi++; obs_consumed++;
        gap = int'($urandom_range(0, gap_max));
      end
      if (dp_in_flag) begin
        last_issue = k;
        obs_issue_k.push_back(k);
        obs_cand.push_back(dp_chash_addr);
        obs_raddr.push_back(mem_raddr);
      end else if (k == last_issue + 1 || k == last_issue + 2) begin
        if (dp_chash_addr !== obs_cand[$]) obs_unstable++;
      end else if (k == last_issue + 3) begin
        obs_cwe.push_back(mem_we);
        obs_cwaddr.push_back(mem_waddr);
      end
      if (done) begin obs_done_k = k; obs_done_cnt++; end
    end
    if (obs_done_cnt == 0) obs_timeout = 1;
    stray = 1'b0;
    @(posedge clk); #1; hin_valid = 1'b1; hin_data = 16'h0155; #1;
    obs_post = {done, busy, hin_ready, mem_we};
    @(posedge clk); #1; hin_valid = 1'b0;

    n_asserts++;
    if (obs_timeout) begin
      n_fail++; $display("FAIL %s timeout: no done within cycle budget", name);
    end
    n_asserts++;
    if (obs_clear_len != 256) begin
      n_fail++; $display("FAIL %s clear_len: got %0d want 256", name, obs_clear_len);
    end
    n_asserts++;
    if (obs_consumed != exp_n || obs_issue_k.size() != exp_n) begin
      n_fail++; $display("FAIL %s consumed/issued: got %0d/%0d want %0d", name,
                         obs_consumed, obs_issue_k.size(), exp_n);
    end
    for (int i = 0; i < exp_n && i < obs_cand.size() && i < obs_cwe.size(); i++) begin
      n_asserts++;
      if (obs_cand[i] !== {6'b0, stim_q[i][9:0]} ||
          obs_raddr[i] !== {3'b011, stim_q[i][9:2]} ||
          obs_cwe[i] !== exp_acc[i] ||
          (exp_acc[i] && obs_cwaddr[i] !== {3'b011, stim_q[i][9:2]})) begin
        n_fail++;
        $display("FAIL %s cand%0d: got chash=%h raddr=%h we=%b waddr=%h want chash=%h raddr=%h we=%b",
                 name, i, obs_cand[i], obs_raddr[i], obs_cwe[i], obs_cwaddr[i],
                 {6'b0, stim_q[i][9:0]}, {3'b011, stim_q[i][9:2]}, exp_acc[i]);
      end
    end
    n_asserts++;
    if (obs_issue_k.size() == 0 || obs_done_k != obs_issue_k[$] + 4 || obs_done_cnt != 1) begin
      n_fail++; $display("FAIL %s done_timing: got done_k=%0d cnt=%0d want last_issue+4, cnt 1",
                         name, obs_done_k, obs_done_cnt);
    end
    n_asserts++;
    if (obs_unstable != 0) begin
      n_fail++; $display("FAIL %s chash_stable: got %0d unstable cycles want 0", name, obs_unstable);
    end
    n_asserts++;
    if (obs_post !== 4'b0000) begin
      n_fail++; $display("FAIL %s post_done {done,busy,ready,we}: got %b want 0000", name, obs_post);
    end
    for (int w = 0; w < 256; w++) begin
      n_asserts++;
      if (ram24[RBASE+w] !== {enc24(exp_coef[2*w+1]), enc24(exp_coef[2*w])} ||
          ram25[RBASE+w] !== {enc25(exp_coef[2*w+1]), enc25(exp_coef[2*w])}) begin
        n_fail++;
        $display("FAIL %s word%0d: got %h/%h want %h/%h", name, w, ram24[RBASE+w], ram25[RBASE+w],
                 {enc24(exp_coef[2*w+1]), enc24(exp_coef[2*w])},
                 {enc25(exp_coef[2*w+1]), enc25(exp_coef[2*w])});
      end
    end
`ifdef CHASH_REJECT_CNT_EN
    n_asserts++;
    if (rej_cnt !== 16'(exp_rej)) begin
      n_fail++; $display("FAIL %s rej_cnt: got %0d want %0d", name, rej_cnt, exp_rej);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b0; hin_valid = 1'b1; hin_data = 16'h0003; stray = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_asserts++;
    if ({busy, done, mem_we, hin_ready, dp_in_flag} !== 5'b0 ||
        dp_chash_addr !== 16'h0 || mem_raddr !== 11'h0 || mem_waddr !== 11'h0 ||
        mem_wdata24 !== 48'h0 || mem_wdata25 !== 50'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b we=%b rdy=%b inf=%b chash=%h ra=%h wa=%h want all 0",
               busy, done, mem_we, hin_ready, dp_in_flag, dp_chash_addr, mem_raddr, mem_waddr);
    end
`ifdef CHASH_REJECT_CNT_EN
    n_asserts++;
    if (rej_cnt !== 16'h0) begin
      n_fail++; $display("FAIL reset_rej_cnt: got %0d want 0", rej_cnt);
    end
`endif
    hin_valid = 1'b0; stray = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
  endtask

  task automatic test_reset_mid_clear();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; #1;
    n_asserts++;
    if (mem_we !== 1'b1 || mem_waddr !== 11'h300) begin
      n_fail++; $display("FAIL clear_first: got we=%b waddr=%h want 1/300", mem_we, mem_waddr);
    end
    repeat (100) @(posedge clk);
    #2;
    n_asserts++;
    if (mem_we !== 1'b1 || mem_waddr !== 11'h364 || busy !== 1'b1) begin
      n_fail++; $display("FAIL clear_wc100: got we=%b waddr=%h busy=%b want 1/364/1", mem_we, mem_waddr, busy);
    end
    rst = 1'b0;
    @(posedge clk); #2;
    n_asserts++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || mem_waddr !== 11'h0) begin
      n_fail++; $display("FAIL reset_mid_clear: got we=%b busy=%b waddr=%h want 0/0/0", mem_we, busy, mem_waddr);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clean_run();
    stim_q = '{16'h0003, 16'h0004, 16'h0201};
    run_stream("clean", 0, 0, 0);
    n_asserts++;
    if (ram24[RBASE][47:24] !== 24'd1 || ram24[RBASE+1][23:0] !== 24'hfc0000 ||
        ram25[RBASE+1][24:0] !== 25'h1fc0000 || ram24[RBASE+128][23:0] !== 24'd1) begin
      n_fail++; $display("FAIL clean_words: got w0=%h w1=%h/%h w128=%h want +1,-1,+1",
                         ram24[RBASE], ram24[RBASE+1], ram25[RBASE+1], ram24[RBASE+128]);
    end
  endtask

  task automatic test_collision();
    stim_q = '{16'h0003, 16'h0002, 16'h0004, 16'h0006};
    run_stream("collision", 0, 0, 1);
    n_asserts++;
    if (obs_cwe.size() < 2 || obs_cwe[1] !== 1'b0 || exp_rej != 1) begin
      n_fail++; $display("FAIL collision_reject: got we=%b want 0", (obs_cwe.size() > 1) ? obs_cwe[1] : 1'bx);
    end
  endtask

  task automatic test_same_word();
    stim_q = '{16'h0003, 16'h0001, 16'h0008};
    run_stream("same_word", 0, 0, 0);
    n_asserts++;
    if (ram24[RBASE] !== {24'd1, 24'd1} || ram25[RBASE] !== {25'd1, 25'd1}) begin
      n_fail++; $display("FAIL same_word_both: got %h/%h want both halves +1", ram24[RBASE], ram25[RBASE]);
    end
  endtask

  task automatic test_stall();
    stim_q = '{16'hfc11, 16'h0020, 16'h0035};
    run_stream("stall", 50, 0, 0);
    n_asserts++;
    if (obs_stall_bad != 0 || obs_issue_k.size() == 0 || obs_issue_k[0] <= 50) begin
      n_fail++; $display("FAIL stall: got bad=%0d first_issue=%0d want 0 / >50", obs_stall_bad,
                         (obs_issue_k.size() > 0) ? obs_issue_k[0] : -1);
    end
  endtask

  task automatic test_start_busy();
    stim_q = '{16'h0041, 16'h0041, 16'h0102, 16'h0300};
    run_stream("start_busy", 0, 1, 0);
    n_asserts++;
    if (!obs_start_hit || obs_after_start_we !== 1'b0) begin
      n_fail++; $display("FAIL start_busy: got hit=%0d we_after=%b want 1/0", obs_start_hit, obs_after_start_we);
    end
  endtask

  task automatic test_random();
    int idx, extra;
    bit narrow;
    for (int r = 0; r < 12; r++) begin
      stim_q.delete();
      narrow = 1'($urandom_range(0, 1));
      for (int i = 0; i < 12; i++) begin
        idx = narrow ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 511));
        stim_q.push_back({6'($urandom()), 9'(idx), 1'($urandom())});
      end
      model_run();
      extra = 0;
      while (exp_pc < TB_W) begin
        stim_q.push_back({6'h2a, 9'(511 - extra), 1'b1});
        extra++;
        model_run();
      end
      run_stream($sformatf("random%0d", r), 0, 0, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_clear();
    test_clean_run();
    test_collision();
    test_same_word();
    test_stall();
    test_start_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
